multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Moore FSM that sequences a multi-cycle RV32 datapath (shared ALU and unified instruction/data memory) for lw, sw, R-type, I-type ALU and beq. It drives the PC, IR, register-file and memory enables and the ALU operand and result muxes. It also emits the 2-bit ALUOp consumed by the existing ALU decoder, plus a retired-instruction counter and an illegal-opcode flag.

Parameters:
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
CLK  input  1  system clock
RST  input  1  synchronous reset, active-high
Opcode  input  7  instr[6:0] from IR
Zero  input  1  ALU zero flag
MemReady  input  1  memory completes current access this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  IR and OldPC enable
ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = rs1 reg A
ALUSrcB  output  2  00 = rs2 reg, 01 = ImmExt, 10 = constant 4
ALUOp  output  2  00 = add, 01 = sub/compare, 10 = funct-decoded
ImmSrc  output  2  00 = I, 01 = S, 10 = B
RegWrite  output  1  register-file write enable
IllegalInstr  output  1  1-cycle pulse on unsupported opcode
State  output  4  current state code, for debug
InstrRetired  output  CNT_WIDTH  count of completed instructions

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, BEQ=9. Codes 10–15 go to FETCH next cycle with all enables 0.
- Reset: on a rising CLK edge with RST=1, State<=FETCH and InstrRetired<=0. While RST=1, PCWrite, IRWrite, MemRead, MemWrite, RegWrite and IllegalInstr are forced to 0. Reset mid-instruction aborts it; no write occurs and the instruction is not counted.
- Default value of every output not listed for a state is 0.
- ImmSrc is combinational from Opcode in all states: 0000011 → 00, 0100011 → 01, 0010011 → 00, 0110011 → 00, 1100011 → 10, other → 00.
- FETCH: MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite = MemReady. Stays in FETCH while MemReady=0, else goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by Opcode:
  - lw or sw → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - other → FETCH with IllegalInstr=1 this cycle
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw → MEMREAD; sw → MEMWRITE.
- MEMREAD: MemRead=1, AdrSrc=1, ResultSrc=00. Holds while MemReady=0, else goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: MemWrite=1, AdrSrc=1, ResultSrc=00. MemWrite is held while MemReady=0; goes to FETCH when MemReady=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite=Zero → FETCH.
- Opcode is sampled only in DECODE and MEMADR; it is stable because IR updates only in FETCH.
- InstrRetired increments by 1, with modulo wrap at 2^CNT_WIDTH, on the edge leaving any of: MEMWB, ALUWB, BEQ, or MEMWRITE with MemReady=1. Illegal opcodes are not counted.
- Latency with MemReady tied to 1: lw 5 cycles, sw 4, R 4, I 4, beq 3, illegal 2. Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Outputs are Moore, plus MemReady/Zero gating on PCWrite and IRWrite. No combinational path exists from Opcode to any enable except IllegalInstr in DECODE.

Test Plan:
- Reset then MemReady=1, Opcode=0000011 → states 0,1,2,3,4,0; RegWrite=1 only in cycle 5 with ResultSrc=01; InstrRetired=1.
- sw (0100011) with MemReady low for 3 cycles in MEMWRITE → MemWrite=1 held 4 cycles, AdrSrc=1, ImmSrc=01; retired increments once, on the ready cycle.
- beq with Zero=1, then beq with Zero=0 → PCWrite=1 in BEQ only for the first, ALUOp=01, ImmSrc=10; both counted (InstrRetired=2).
- R-type then I-type back-to-back → EXECR has ALUSrcB=00 and EXECI has ALUSrcB=01, both with ALUOp=10; ALUWB RegWrite=1; 8 cycles total.
- Opcode=1101111 → IllegalInstr=1 exactly in DECODE, next state FETCH, no RegWrite/MemWrite, InstrRetired unchanged.
- RST=1 asserted in MEMREAD → next cycle State=0, InstrRetired=0, all enables 0 during reset; CNT_WIDTH=4 with 17 R-types → InstrRetired=1 (wrap).

Source files
------------

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multi-cycle RV32 datapath (lw, sw, R-type, I-type ALU, beq)
// with shared ALU and unified memory, plus a retired-instruction counter.
module multicycle_controller #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [6:0]           Opcode,
    input  logic                 Zero,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [1:0]           ImmSrc,
    output logic                 RegWrite,
    output logic                 IllegalInstr,
    output logic [3:0]           State,
    output logic [CNT_WIDTH-1:0] InstrRetired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_BEQ      = 4'd9
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Raw enables before reset gating.
    logic pc_we, ir_we, mem_rd, mem_wr, reg_we, illegal, retire;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d   = S_FETCH;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        reg_we    = 1'b0;
        illegal   = 1'b0;
        retire    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_rd    = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_we     = MemReady;
                ir_we     = MemReady;
                state_d   = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                if (Opcode == OP_LW)      state_d = S_MEMREAD;
                else if (Opcode == OP_SW) state_d = S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_rd  = 1'b1;
                AdrSrc  = 1'b1;
                state_d = MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_we    = 1'b1;
                retire    = 1'b1;
            end
            S_MEMWRITE: begin
                mem_wr  = 1'b1;
                AdrSrc  = 1'b1;
                retire  = MemReady;
                state_d = MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we = 1'b1;
                retire = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                pc_we   = Zero;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        cnt_d = retire ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end

    always_comb begin
        case (Opcode)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Write/request enables are held off for as long as reset is asserted.
    assign PCWrite      = pc_we   & ~RST;
    assign IRWrite      = ir_we   & ~RST;
    assign MemRead      = mem_rd  & ~RST;
    assign MemWrite     = mem_wr  & ~RST;
    assign RegWrite     = reg_we  & ~RST;
    assign IllegalInstr = illegal & ~RST;
    assign State        = state_q;
    assign InstrRetired = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller: each instruction is expanded
// into its expected state walk and checked cycle by cycle against a table of control words.
module tb_multicycle_controller;

    localparam int CW = 4;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] BEQ = 7'b1100011;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [6:0]    Opcode = 7'd0;
    logic          Zero = 1'b0;
    logic          MemReady = 1'b0;
    logic          PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, IllegalInstr;
    logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0]    State;
    logic [CW-1:0] InstrRetired;

    int checks = 0;
    int failures = 0;
    int model_cnt = 0;
    int cycles = 0;

    multicycle_controller #(.CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .IllegalInstr(IllegalInstr),
        .State(State), .InstrRetired(InstrRetired)
    );

    always #5 CLK = ~CLK;

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {LW, SW, IT, RT, BEQ};
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] op);
        if (op == SW)  return 2'b01;
        if (op == BEQ) return 2'b10;
        return 2'b00;
    endfunction

    // Control word: {PCWrite,AdrSrc,MemRead,MemWrite,IRWrite,RegWrite,IllegalInstr,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
    function automatic logic [14:0] exp_ctrl(input int st, input logic mr, input logic z,
                                              input logic [6:0] op);
        logic pcw, adr, mrd, mwr, irw, rw, ill;
        logic [1:0] rs, sa, sb, ao;
        {pcw, adr, mrd, mwr, irw, rw, ill} = 7'b0;
        {rs, sa, sb, ao} = 8'b0;
        case (st)
            0: begin mrd = 1; sb = 2; rs = 2; irw = mr; pcw = mr; end
            1: begin sa = 1; sb = 1; ill = !is_legal(op); end
            2: begin sa = 2; sb = 1; end
            3: begin mrd = 1; adr = 1; end
            4: begin rs = 1; rw = 1; end
            5: begin mwr = 1; adr = 1; end
            6: begin sa = 2; sb = 0; ao = 2; end
            7: begin rw = 1; end
            8: begin sa = 2; sb = 1; ao = 2; end
            9: begin sa = 2; sb = 0; ao = 1; pcw = z; end
            default: ;
        endcase
        return {pcw, adr, mrd, mwr, irw, rw, ill, rs, sa, sb, ao};
    endfunction

    function automatic logic [14:0] act_ctrl();
        return {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, IllegalInstr,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
    endfunction

    // One clock of an instruction walk: drive inputs, check everything, then advance.
    task automatic step(input int st, input logic [6:0] op, input logic mr, input logic z,
                        input bit retire);
        logic [14:0] exp;
        @(negedge CLK);
        RST = 1'b0; Opcode = op; MemReady = mr; Zero = z;
        #1;
        exp = exp_ctrl(st, mr, z, op);
        checks++;
        if (State !== 4'(st)) begin
            failures++;
            $display("FAIL state: got %0d expected %0d (op=%b)", State, st, op);
        end
        checks++;
        if (act_ctrl() !== exp) begin
            failures++;
            $display("FAIL ctrl st=%0d: got %b expected %b", st, act_ctrl(), exp);
        end
        checks++;
        if (ImmSrc !== exp_imm(op)) begin
            failures++;
            $display("FAIL immsrc: got %b expected %b", ImmSrc, exp_imm(op));
        end
        checks++;
        if (InstrRetired !== CW'(model_cnt)) begin
            failures++;
            $display("FAIL retired: got %0d expected %0d", InstrRetired, model_cnt);
        end
        @(posedge CLK);
        cycles++;
        if (retire) model_cnt = (model_cnt + 1) % (1 << CW);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expands one instruction into the state walk it must follow.
    task automatic run_instr(input logic [6:0] op, input int fstall, input int mstall,
                             input logic z);
        repeat (fstall) step(0, op, 1'b0, z, 0);
        step(0, op, 1'b1, z, 0);
        step(1, op, rbit(), z, 0);
        case (op)
            LW: begin
                step(2, op, rbit(), z, 0);
                repeat (mstall) step(3, op, 1'b0, z, 0);
                step(3, op, 1'b1, z, 0);
                step(4, op, rbit(), z, 1);
            end
            SW: begin
                step(2, op, rbit(), z, 0);
                repeat (mstall) step(5, op, 1'b0, z, 0);
                step(5, op, 1'b1, z, 1);
            end
            RT: begin step(6, op, rbit(), z, 0); step(7, op, rbit(), z, 1); end
            IT: begin step(8, op, rbit(), z, 0); step(7, op, rbit(), z, 1); end
            BEQ: step(9, op, rbit(), z, 1);
            default: ;
        endcase
    endtask

    task automatic check_gated(input string name);
        checks++;
        if ({PCWrite, IRWrite, MemRead, MemWrite, RegWrite, IllegalInstr} !== 6'b0) begin
            failures++;
            $display("FAIL %s enables: got %b expected 000000", name,
                     {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, IllegalInstr});
        end
    endtask

    // Leaves RST asserted; the next step() releases it.
    task automatic apply_reset();
        @(negedge CLK);
        RST = 1'b1; MemReady = 1'b1; Zero = 1'b1; Opcode = RT;
        @(posedge CLK);
        @(negedge CLK);
        #1;
        model_cnt = 0;
        checks++;
        if (State !== 4'd0 || InstrRetired !== '0) begin
            failures++;
            $display("FAIL reset: state=%0d retired=%0d expected 0/0", State, InstrRetired);
        end
        check_gated("reset");
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_lw();
        int c0;
        apply_reset();
        c0 = cycles;
        run_instr(LW, 0, 0, 1'b0);
        checks++;
        if (cycles - c0 != 5 || model_cnt != 1) begin
            failures++;
            $display("FAIL lw_latency: cycles=%0d expected 5", cycles - c0);
        end
    endtask

    task automatic test_sw_stall();
        int c0;
        c0 = cycles;
        run_instr(SW, 0, 3, 1'b0);
        checks++;
        if (cycles - c0 != 7) begin
            failures++;
            $display("FAIL sw_stall_latency: cycles=%0d expected 7", cycles - c0);
        end
    endtask

    task automatic test_beq();
        apply_reset();
        run_instr(BEQ, 0, 0, 1'b1);
        run_instr(BEQ, 0, 0, 1'b0);
        step(0, RT, 1'b0, 1'b0, 0);
        checks++;
        if (InstrRetired !== CW'(2)) begin
            failures++;
            $display("FAIL beq_count: got %0d expected 2", InstrRetired);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = cycles;
        run_instr(RT, 0, 0, 1'b0);
        run_instr(IT, 0, 0, 1'b0);
        checks++;
        if (cycles - c0 != 8) begin
            failures++;
            $display("FAIL r_i_latency: cycles=%0d expected 8", cycles - c0);
        end
    endtask

    task automatic test_illegal();
        int c0, n0;
        c0 = cycles;
        n0 = model_cnt;
        run_instr(7'b1101111, 0, 0, 1'b0);
        step(0, RT, 1'b0, 1'b0, 0);
        checks++;
        if (cycles - c0 != 3 || InstrRetired !== CW'(n0)) begin
            failures++;
            $display("FAIL illegal: cycles=%0d retired=%0d expected 3/%0d",
                     cycles - c0, InstrRetired, n0);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        run_instr(RT, 0, 0, 1'b0);
        step(0, LW, 1'b1, 1'b0, 0);
        step(1, LW, 1'b1, 1'b0, 0);
        step(2, LW, 1'b1, 1'b0, 0);
        @(negedge CLK);
        RST = 1'b1; MemReady = 1'b1; Opcode = LW;
        #1;
        checks++;
        if (State !== 4'd3) begin
            failures++;
            $display("FAIL reset_mid_state: got %0d expected 3", State);
        end
        check_gated("reset_mid");
        @(posedge CLK);
        @(negedge CLK);
        #1;
        model_cnt = 0;
        checks++;
        if (State !== 4'd0 || InstrRetired !== '0) begin
            failures++;
            $display("FAIL reset_mid_after: state=%0d retired=%0d expected 0/0",
                     State, InstrRetired);
        end
        check_gated("reset_mid_after");
    endtask

    task automatic test_wrap();
        apply_reset();
        repeat (17) run_instr(RT, $urandom_range(0, 1), 0, rbit());
        step(0, RT, 1'b0, 1'b0, 0);
        checks++;
        if (InstrRetired !== CW'(1)) begin
            failures++;
            $display("FAIL wrap: got %0d expected 1", InstrRetired);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [0:8];
        ops = '{LW, SW, IT, RT, BEQ, 7'b1101111, 7'b0110111, 7'b0000000, 7'b1110011};
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            run_instr(ops[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 3),
                      rbit());
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_beq();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
